scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Sequences one face scan of the cube.
- At each of NUM_POS sticker positions it collects NUM_SAMPLES RGB readings (edge and corner sensor), averages them and drives the averages into color_translator.
- It captures the translated edge/corner colors, writes them into the facelet store, then commands the motor to step to the next position.
- Sits between the sensor front end, color_translator, the facelet RAM and the motor controller.

Parameters:
- NUM_POS, 4, positions per scan (edge/corner pairs); also the number of writes per scan.
- SAMPLES_LOG2, 2, log2 of readings averaged per position (NUM_SAMPLES = 4).
- ADDR_W, 2, width of wr_addr; must satisfy 2^ADDR_W >= NUM_POS.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a scan when idle
- abort  in  1  returns to IDLE from any state next cycle
- known_valid  in  1  known_color is valid for this scan
- known_color  in  3  edge color known from the previous face, W=0..Y=5
- sample_req  out  1  request one sensor reading
- sample_valid  in  1  reading present on *_in this cycle
- r_edge_in, g_edge_in, b_edge_in  in  8 each  edge sensor reading
- r_corner_in, g_corner_in, b_corner_in  in  8 each  corner sensor reading
- xl_r_edge, xl_g_edge, xl_b_edge, xl_r_corner, xl_g_corner, xl_b_corner  out  8 each  averaged values to the translator
- xl_known  out  3  known_edge_color to the translator
- xl_color_edge, xl_color_corner  in  3 each  translator outputs
- wr_en  out  1  facelet write strobe
- wr_addr  out  ADDR_W  position index
- wr_data  out  6  {color_edge, color_corner}
- step_req  out  1  motor step request
- step_done  in  1  motor step complete, one-cycle pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset: state=IDLE; pos=0; sample count=0; accumulators=0; every output 0, except xl_known=3'd7 (unknown, which selects the translator's default branch).
- start sampled only in IDLE; ignored while busy. known_color/known_valid latched on start; xl_known = known_valid ? known_color : 3'd7 for the whole scan.
- IDLE --start--> REQ.
- REQ: sample_req=1, held until sample_valid (sample_valid in the same cycle is legal). On sample_valid:
  - add the six readings into six accumulators, each 8+SAMPLES_LOG2 bits;
  - increment the count;
  - if count reaches NUM_SAMPLES-1 go to AVG, else stay in REQ.
  - sample_valid outside REQ is ignored.
- AVG, 1 cycle:
  - xl_* <= accumulator >> SAMPLES_LOG2, truncated to 8 bits (no rounding);
  - clear accumulators and count.
  - -> XLATE.
- XLATE, exactly 2 cycles: covers the translator's 1-cycle registered latency. On the second cycle, capture {xl_color_edge, xl_color_corner} into wr_data. -> WRITE.
- WRITE, 1 cycle: wr_en=1, wr_addr=pos. If pos==NUM_POS-1 -> FIN, else -> STEP.
- STEP: step_req=1 until step_done, then pos <= pos+1 and -> REQ. A step_done pulse arriving in the same cycle that STEP is entered is honoured.
- FIN: done=1 for 1 cycle, pos <= 0 -> IDLE. No motor step after the last position.
- xl_* hold their value outside AVG.
- abort or reset mid-scan:
  - -> IDLE next edge; all strobes (sample_req, wr_en, step_req) drop;
  - pos, count and accumulators cleared; no done pulse;
  - a write in progress is suppressed if abort is asserted during WRITE.
- Minimum per-position latency, with sample_valid and step_done always high: NUM_SAMPLES + 1 + 2 + 1 + 1 cycles.

Test Plan:
- Basic scan: start with known_valid=0; every reading r=10, g=9, b=3 (edge and corner); step_done 2 cycles after step_req -> 4 writes at addr 0..3, xl_known=7, xl_r_edge=10, exactly 3 step_req episodes, one done pulse, busy falls the cycle after done.
- Averaging/truncation: edge r readings 1,2,2,2 -> xl_r_edge=1; readings 255 x4 -> 255, no overflow.
- Handshake stalls: sample_valid delayed 0/3/7 cycles per request -> sample_req held through each stall and no extra samples accumulated; a stray sample_valid in IDLE has no effect.
- Known color: start with known_valid=1, known_color=3 -> xl_known=3 for the entire scan; wr_data equals the translator stub output {3'd3, corner} captured on the second XLATE cycle.
- Abort: assert abort during STEP of pos 1 -> next cycle IDLE with all strobes low; no done pulse; a subsequent start writes from addr 0 again.
- Reset mid-REQ plus start while busy: sync reset -> all outputs at reset values and xl_known=7; a start pulse during STEP is ignored (exactly one done pulse per scan).

Source files
------------

// File: rtl/scan_sequencer.sv
// One face scan: per position, average NUM_SAMPLES edge/corner RGB readings, translate,
// store the facelet pair, then step the motor.
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | requesting/accumulating sensor readings
// AVG    | dividing accumulators into xl_* outputs
// XLATE  | two cycles waiting on the translator, captures on the second
// WRITE  | facelet store write of the captured pair
// STEP   | motor step request until step_done
// FIN    | scan-complete pulse
module scan_sequencer #(
  parameter int NUM_POS      = 4,
  parameter int SAMPLES_LOG2 = 2,
  parameter int ADDR_W       = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              known_valid,
  input  logic [2:0]        known_color,
  output logic              sample_req,
  input  logic              sample_valid,
  input  logic [7:0]        r_edge_in,
  input  logic [7:0]        g_edge_in,
  input  logic [7:0]        b_edge_in,
  input  logic [7:0]        r_corner_in,
  input  logic [7:0]        g_corner_in,
  input  logic [7:0]        b_corner_in,
  output logic [7:0]        xl_r_edge,
  output logic [7:0]        xl_g_edge,
  output logic [7:0]        xl_b_edge,
  output logic [7:0]        xl_r_corner,
  output logic [7:0]        xl_g_corner,
  output logic [7:0]        xl_b_corner,
  output logic [2:0]        xl_known,
  input  logic [2:0]        xl_color_edge,
  input  logic [2:0]        xl_color_corner,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [5:0]        wr_data,
  output logic              step_req,
  input  logic              step_done,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = 8 + SAMPLES_LOG2;
  localparam int CNT_W = (SAMPLES_LOG2 > 0) ? SAMPLES_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << SAMPLES_LOG2) - 1);
  localparam logic [ADDR_W-1:0] POS_LAST = ADDR_W'(NUM_POS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_AVG   = 3'd2;
  localparam logic [2:0] S_XLATE = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_STEP  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pos;
  logic [CNT_W-1:0]  cnt;
  logic              xl_phase;
  logic [ACC_W-1:0]  acc  [6];
  logic [7:0]        xl_q [6];
  logic [7:0]        rd   [6];

  always_comb begin
    rd[0] = r_edge_in;
    rd[1] = g_edge_in;
    rd[2] = b_edge_in;
    rd[3] = r_corner_in;
    rd[4] = g_corner_in;
    rd[5] = b_corner_in;
  end

  assign xl_r_edge   = xl_q[0];
  assign xl_g_edge   = xl_q[1];
  assign xl_b_edge   = xl_q[2];
  assign xl_r_corner = xl_q[3];
  assign xl_g_corner = xl_q[4];
  assign xl_b_corner = xl_q[5];

  // Write and done are gated so an abort/reset in their cycle suppresses them.
  assign sample_req = (state == S_REQ);
  assign wr_en      = (state == S_WRITE) && !abort && !reset;
  assign wr_addr    = pos;
  assign step_req   = (state == S_STEP);
  assign done       = (state == S_FIN) && !abort && !reset;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      pos      <= '0;
      cnt      <= '0;
      xl_phase <= 1'b0;
      wr_data  <= '0;
      xl_known <= 3'd7;
      for (int i = 0; i < 6; i++) begin
        acc[i]  <= '0;
        xl_q[i] <= '0;
      end
    end else if (abort) begin
      state    <= S_IDLE;
      pos      <= '0;
      cnt      <= '0;
      xl_phase <= 1'b0;
      for (int i = 0; i < 6; i++) acc[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_REQ;
            xl_known <= known_valid ? known_color : 3'd7;
          end
        end
        S_REQ: begin
          if (sample_valid) begin
            for (int i = 0; i < 6; i++) acc[i] <= acc[i] + ACC_W'(rd[i]);
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state <= S_AVG;
          end
        end
        S_AVG: begin
          for (int i = 0; i < 6; i++) begin
            xl_q[i] <= 8'(acc[i] >> SAMPLES_LOG2);
            acc[i]  <= '0;
          end
          cnt      <= '0;
          xl_phase <= 1'b0;
          state    <= S_XLATE;
        end
        S_XLATE: begin
          // Translator registers on the first cycle; its result is valid on the second.
          if (xl_phase) begin
            wr_data  <= {xl_color_edge, xl_color_corner};
            xl_phase <= 1'b0;
            state    <= S_WRITE;
          end else begin
            xl_phase <= 1'b1;
          end
        end
        S_WRITE: begin
          state <= (pos == POS_LAST) ? S_FIN : S_STEP;
        end
        S_STEP: begin
          if (step_done) begin
            pos   <= pos + ADDR_W'(1);
            state <= S_REQ;
          end
        end
        S_FIN: begin
          pos   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized bench for scan_sequencer: arithmetic reference model feeds a write scoreboard,
// plus directed abort/reset/latency scenarios.
module tb_scan_sequencer;
  localparam int NUM_POS = 4;
  localparam int NS      = 4;
  localparam int ADDR_W  = 2;

  logic clock = 1'b0;
  logic reset, start, abort, known_valid;
  logic [2:0] known_color;
  logic sample_req;
  logic sample_valid = 1'b0;
  logic [7:0] r_edge_in = 8'd0, g_edge_in = 8'd0, b_edge_in = 8'd0;
  logic [7:0] r_corner_in = 8'd0, g_corner_in = 8'd0, b_corner_in = 8'd0;
  logic [7:0] xl_r_edge, xl_g_edge, xl_b_edge, xl_r_corner, xl_g_corner, xl_b_corner;
  logic [2:0] xl_known;
  logic [2:0] xl_color_edge, xl_color_corner;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0] wr_data;
  logic step_req;
  logic step_done = 1'b0;
  logic busy, done;

  scan_sequencer #(.NUM_POS(NUM_POS), .SAMPLES_LOG2(2), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .known_valid(known_valid), .known_color(known_color),
    .sample_req(sample_req), .sample_valid(sample_valid),
    .r_edge_in(r_edge_in), .g_edge_in(g_edge_in), .b_edge_in(b_edge_in),
    .r_corner_in(r_corner_in), .g_corner_in(g_corner_in), .b_corner_in(b_corner_in),
    .xl_r_edge(xl_r_edge), .xl_g_edge(xl_g_edge), .xl_b_edge(xl_b_edge),
    .xl_r_corner(xl_r_corner), .xl_g_corner(xl_g_corner), .xl_b_corner(xl_b_corner),
    .xl_known(xl_known), .xl_color_edge(xl_color_edge), .xl_color_corner(xl_color_corner),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step_req(step_req), .step_done(step_done), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Translator stub with one cycle of registered latency.
  always @(posedge clock) begin
    xl_color_edge   <= (xl_known != 3'd7) ? xl_known : (xl_r_edge[2:0] ^ xl_g_edge[2:0]);
    xl_color_corner <= xl_r_corner[2:0] + xl_b_corner[2:0];
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Stimulus configuration, written only by the main initial block.
  bit stall_en = 0, stray = 0, always_step = 0, lat_check = 0;
  int step_delay = 2;
  int mode = 0;
  int exp_known = 7;

  int pat_idx = 0;
  int stall = 0;
  int sdel = 0;

  function automatic logic [7:0] pattern(int idx);
    return ((idx % 8) == 0) ? 8'd1 : ((idx % 8) < 4) ? 8'd2 : 8'd255;
  endfunction

  task automatic drive_reading();
    if (mode == 1) begin
      r_edge_in = 8'd10; g_edge_in = 8'd9; b_edge_in = 8'd3;
      r_corner_in = 8'd10; g_corner_in = 8'd9; b_corner_in = 8'd3;
    end else begin
      r_edge_in = 8'($urandom); g_edge_in = 8'($urandom); b_edge_in = 8'($urandom);
      r_corner_in = 8'($urandom); g_corner_in = 8'($urandom); b_corner_in = 8'($urandom);
      if (mode == 2) begin
        r_edge_in = pattern(pat_idx);
        pat_idx++;
      end
    end
  endtask

  // Sensor front end: answers sample_req after 0/3/7 stall cycles, optional stray pulses.
  always begin
    @(posedge clock); #1;
    sample_valid = 1'b0;
    if (sample_req) begin
      if (stall > 0) stall--;
      else begin
        drive_reading();
        sample_valid = 1'b1;
        case (stall_en ? $urandom_range(2, 0) : 0)
          1: stall = 3;
          2: stall = 7;
          default: stall = 0;
        endcase
      end
    end else if (stray && ($urandom_range(3, 0) == 0)) begin
      drive_reading();
      sample_valid = 1'b1;
    end
  end

  // Motor: step_done pulse step_delay cycles after step_req, or held high.
  always begin
    @(posedge clock); #1;
    if (always_step) step_done = 1'b1;
    else begin
      step_done = 1'b0;
      if (step_req) begin
        if (sdel > 0) sdel--;
        else begin
          step_done = 1'b1;
          sdel = step_delay;
        end
      end else sdel = step_delay;
    end
  end

  // Reference model and scoreboard.
  typedef struct { int addr; int data; int xre; int xbc; } exp_t;
  exp_t exp_q[$];
  int s[6];
  int cnt_m = 0, pos_m = 0;
  int cyc = 0, last_wr = -1;
  int done_cnt = 0, step_eps = 0, writes = 0;
  bit prev_req = 0, prev_valid = 0, prev_ctl = 1, prev_step = 0, prev_done = 0;

  always @(negedge clock) begin
    cyc++;
    if (reset || abort) begin
      exp_q.delete();
      cnt_m = 0;
      pos_m = 0;
      for (int i = 0; i < 6; i++) s[i] = 0;
    end else if (sample_req && sample_valid) begin
      s[0] += r_edge_in;   s[1] += g_edge_in;   s[2] += b_edge_in;
      s[3] += r_corner_in; s[4] += g_corner_in; s[5] += b_corner_in;
      cnt_m++;
      if (cnt_m == NS) begin
        int ae[6];
        int e_col, c_col;
        exp_t e;
        for (int i = 0; i < 6; i++) ae[i] = s[i] / NS;
        e_col = (exp_known != 7) ? exp_known : ((ae[0] ^ ae[1]) & 7);
        c_col = (ae[3] + ae[5]) & 7;
        e.addr = pos_m;
        e.data = e_col * 8 + c_col;
        e.xre  = ae[0];
        e.xbc  = ae[5];
        exp_q.push_back(e);
        pos_m = (pos_m + 1) % NUM_POS;
        cnt_m = 0;
        for (int i = 0; i < 6; i++) s[i] = 0;
      end
    end
    if (start && !busy && !reset && !abort) last_wr = -1;
    if (wr_en) begin
      writes++;
      if (exp_q.size() == 0) chk("write_unexpected", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
        chk("xl_r_edge", int'(xl_r_edge), e.xre);
        chk("xl_b_corner", int'(xl_b_corner), e.xbc);
      end
      if (lat_check && last_wr >= 0) chk("write_gap_cycles", cyc - last_wr, NS + 1 + 2 + 1 + 1);
      last_wr = cyc;
    end
    if (done) done_cnt++;
    if (step_req && !prev_step) step_eps++;
    if (busy && !reset) chk("xl_known", int'(xl_known), exp_known);
    if (prev_done) chk("busy_after_done", int'(busy), 0);
    if (prev_req && !prev_valid && !prev_ctl) chk("sample_req_held", int'(sample_req), 1);
    prev_req   = sample_req;
    prev_valid = sample_valid;
    prev_ctl   = reset || abort;
    prev_step  = step_req;
    prev_done  = done;
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_sample_req"}, int'(sample_req), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_step_req"}, int'(step_req), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_xl_r_edge"}, int'(xl_r_edge), 0);
    chk({tag, "_xl_g_corner"}, int'(xl_g_corner), 0);
    chk({tag, "_xl_known"}, int'(xl_known), 7);
  endtask

  task automatic pulse_start(bit kv, logic [2:0] kc);
    @(posedge clock); #1;
    pat_idx = 0;
    known_valid = kv;
    known_color = kc;
    start = 1'b1;
    exp_known = kv ? int'(kc) : 7;
    @(posedge clock); #1;
    start = 1'b0;
    known_valid = 1'b0;
    known_color = 3'd0;
  endtask

  task automatic run_scan(string tag, bit kv, logic [2:0] kc, bit start_in_step);
    int d0, e0, w0;
    bit ok;
    d0 = done_cnt; e0 = step_eps; w0 = writes;
    pulse_start(kv, kc);
    if (start_in_step) begin
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(negedge clock); #1;
        if (step_req) ok = 1;
      end
      chk({tag, "_step_seen"}, int'(ok), 1);
      @(posedge clock); #1;
      start = 1'b1; known_valid = 1'b1; known_color = 3'd5;
      @(posedge clock); #1;
      start = 1'b0; known_valid = 1'b0; known_color = 3'd0;
    end
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock); #1;
      if (done) ok = 1;
    end
    chk({tag, "_done_seen"}, int'(ok), 1);
    repeat (2) @(negedge clock);
    #1;
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_step_episodes"}, step_eps - e0, NUM_POS - 1);
    chk({tag, "_writes"}, writes - w0, NUM_POS);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    bit ok;
    int d0, e0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; known_valid = 1'b0; known_color = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Basic scan with constant readings and 2-cycle motor.
    mode = 1; step_delay = 2;
    run_scan("basic", 1'b0, 3'd0, 1'b0);
    chk("basic_xl_r_edge", int'(xl_r_edge), 10);

    // Truncation and full-scale averaging.
    mode = 2; step_delay = 1;
    run_scan("trunc", 1'b0, 3'd0, 1'b0);

    // Stalls plus stray sample_valid outside REQ.
    mode = 0; stall_en = 1; stray = 1;
    run_scan("stall", 1'b0, 3'd0, 1'b0);

    // Known color and an ignored start during STEP.
    stall_en = 0; stray = 0; step_delay = 3;
    run_scan("known", 1'b1, 3'd3, 1'b1);

    // Minimum latency: sample_valid and step_done always ready.
    always_step = 1; lat_check = 1;
    run_scan("latency", 1'b0, 3'd0, 1'b0);
    always_step = 0; lat_check = 0;

    // Abort during STEP of position 1.
    step_delay = 5;
    d0 = done_cnt; e0 = step_eps;
    pulse_start(1'b0, 3'd0);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock); #1;
      if (step_req && step_eps == e0 + 2) ok = 1;
    end
    chk("abort_step1_seen", int'(ok), 1);
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sample_req", int'(sample_req), 0);
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_step_req", int'(step_req), 0);
    repeat (20) @(negedge clock);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    step_delay = 2;
    run_scan("after_abort", 1'b0, 3'd0, 1'b0);

    // Reset in the middle of REQ.
    stall_en = 1;
    pulse_start(1'b1, 3'd2);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock); #1;
      if (sample_req && writes > 0) ok = 1;
    end
    chk("reset_req_seen", int'(ok), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_vals("midreset");
    reset = 1'b0;

    // Randomized scans.
    for (int n = 0; n < 6; n++) begin
      mode = 0;
      stall_en = 1'($urandom);
      stray = 1'($urandom);
      step_delay = $urandom_range(3, 0);
      run_scan("random", 1'($urandom), 3'($urandom_range(5, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
